// File: rtl/pll_trim_ctrl.sv
// pll_trim_ctrl: digital frequency-lock loop for the 8x PLL.
// Measures CLK cycles per REF period and nudges the bias trim code.
module pll_trim_ctrl #(
    parameter int TRIM_W    = 4,
    parameter int TRIM_INIT = 8,
    parameter int MULT_W    = 6,
    parameter int CNT_W     = 10,
    parameter int TOL       = 1,
    parameter int LOCK_CNT  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              REF,
    input  logic [MULT_W-1:0] MULT,
    output logic [TRIM_W-1:0] TRIM,
    output logic              LOCK,
    output logic              FAULT,
    output logic [CNT_W-1:0]  COUNT
);

    localparam int W     = CNT_W + 1;
    localparam int WIN_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [TRIM_W-1:0] TRIM_MAX = '1;
    localparam logic [TRIM_W-1:0] TRIM_RST = TRIM_W'(TRIM_INIT);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        TRACK,
        LOCKED
    } state_t;

    state_t state, state_nx;

    logic ref_s1, ref_s2, ref_d;
    logic ref_rise;

    logic [CNT_W-1:0]  cnt, cnt_nx, count_nx;
    logic [TRIM_W-1:0] trim_nx;
    logic              lock_nx, fault_nx;
    logic [WIN_W-1:0]  win, win_nx;

    logic [W-1:0] meas, mult_w, tol_w, tol2_w;
    logic [W-1:0] lo, hi, lo2, hi2;
    logic         below, above, lost;

    assign ref_rise = ref_s2 & ~ref_d;

    // Window bounds, widened by one bit so MULT+2*TOL cannot wrap.
    assign meas   = {1'b0, cnt};
    assign mult_w = W'(MULT);
    assign tol_w  = W'(TOL);
    assign tol2_w = W'(2 * TOL);
    assign lo     = (mult_w > tol_w) ? mult_w - tol_w : '0;
    assign hi     = mult_w + tol_w;
    assign lo2    = (mult_w > tol2_w) ? mult_w - tol2_w : '0;
    assign hi2    = mult_w + tol2_w;
    assign below  = meas < lo;
    assign above  = meas > hi;
    assign lost   = (meas < lo2) || (meas > hi2);

    // REF synchroniser and edge-detect flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_d  <= 1'b0;
        end else begin
            ref_s1 <= REF;
            ref_s2 <= ref_s1;
            ref_d  <= ref_s2;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            win   <= '0;
            COUNT <= '0;
            TRIM  <= TRIM_RST;
            LOCK  <= 1'b0;
            FAULT <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            win   <= win_nx;
            COUNT <= count_nx;
            TRIM  <= trim_nx;
            LOCK  <= lock_nx;
            FAULT <= fault_nx;
        end
    end

    // Next-state and datapath; EN low forces IDLE over everything else.
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        count_nx = COUNT;
        trim_nx  = TRIM;
        lock_nx  = LOCK;
        fault_nx = FAULT;
        win_nx   = win;

        case (state)
            IDLE: begin
                cnt_nx   = '0;
                state_nx = ARM;
            end
            ARM: begin
                if (ref_rise) begin
                    cnt_nx   = CNT_W'(1);
                    win_nx   = '0;
                    state_nx = TRACK;
                end
            end
            TRACK, LOCKED: begin
                if (ref_rise) begin
                    count_nx = cnt;
                    cnt_nx   = CNT_W'(1);
                    if (below) begin
                        if (TRIM == TRIM_MAX) fault_nx = 1'b1;
                        else trim_nx = TRIM + TRIM_W'(1);
                    end else if (above) begin
                        if (TRIM == '0) fault_nx = 1'b1;
                        else trim_nx = TRIM - TRIM_W'(1);
                    end
                    if (state == TRACK) begin
                        if (below || above) begin
                            win_nx = '0;
                        end else begin
                            win_nx = win + WIN_W'(1);
                            if (win_nx == WIN_W'(LOCK_CNT)) begin
                                lock_nx  = 1'b1;
                                state_nx = LOCKED;
                            end
                        end
                    end else if (lost) begin
                        win_nx   = '0;
                        lock_nx  = 1'b0;
                        state_nx = TRACK;
                    end
                end else if (cnt == CNT_MAX) begin
                    win_nx   = '0;
                    lock_nx  = 1'b0;
                    state_nx = ARM;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (!EN) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            win_nx   = '0;
            trim_nx  = TRIM_RST;
            lock_nx  = 1'b0;
            fault_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_pll_trim_ctrl.sv
// tb_pll_trim_ctrl: directed bench for the PLL trim controller.
// REF is driven on negedges; outputs are checked on negedges.
module tb_pll_trim_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ref_clk;
    logic [5:0] mult;
    logic [3:0] trim;
    logic       lock;
    logic       fault;
    logic [9:0] count;

    int checks;
    int failures;

    pll_trim_ctrl dut (
        .CLK   (clk),
        .RST   (rst),
        .EN    (en),
        .REF   (ref_clk),
        .MULT  (mult),
        .TRIM  (trim),
        .LOCK  (lock),
        .FAULT (fault),
        .COUNT (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One REF period of p CLK cycles, starting with the rising edge.
    task automatic ref_period(input int p);
        ref_clk = 1'b1;
        repeat (p / 2) @(negedge clk);
        ref_clk = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        ref_clk  = 1'b0;
        mult     = 6'd8;

        #2;
        check("rst_trim", 32'(trim), 32'd8);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);

        // Period 8: first edge arms, four measurements lock.
        ref_period(8);
        check("arm_count", 32'(count), 32'd0);
        check("arm_lock", 32'(lock), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            ref_period(8);
            check("p8_count", 32'(count), 32'd8);
            check("p8_trim", 32'(trim), 32'd8);
            check("p8_lock", 32'(lock), (i == 4) ? 32'd1 : 32'd0);
        end

        // Period 10 stays locked; period 11 drops lock.
        ref_period(10);
        check("p10_pre_lock", 32'(lock), 32'd1);
        ref_period(11);
        check("p10_count", 32'(count), 32'd10);
        check("p10_trim", 32'(trim), 32'd7);
        check("p10_lock", 32'(lock), 32'd1);
        ref_period(8);
        check("p11_count", 32'(count), 32'd11);
        check("p11_trim", 32'(trim), 32'd6);
        check("p11_lock", 32'(lock), 32'd0);

        // Relock, then lose REF.
        for (int i = 1; i <= 4; i++) ref_period(8);
        check("relock", 32'(lock), 32'd1);
        check("relock_trim", 32'(trim), 32'd6);
        repeat (1000) @(negedge clk);
        check("loss_early", 32'(lock), 32'd1);
        repeat (30) @(negedge clk);
        check("loss_lock", 32'(lock), 32'd0);
        check("loss_trim", 32'(trim), 32'd6);
        ref_period(8);
        check("rearm_count", 32'(count), 32'd8);
        check("rearm_trim", 32'(trim), 32'd6);

        // Disable, then period 6 drives TRIM to saturation.
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_trim", 32'(trim), 32'd8);
        check("dis_lock", 32'(lock), 32'd0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        ref_period(6);
        for (int i = 1; i <= 7; i++) begin
            ref_period(6);
            check("p6_trim", 32'(trim), 32'(8 + i));
            check("p6_fault", 32'(fault), 32'd0);
        end
        ref_period(6);
        check("sat_trim", 32'(trim), 32'd15);
        check("sat_fault", 32'(fault), 32'd1);
        check("sat_lock", 32'(lock), 32'd0);

        // Walk down to 12 with FAULT still set, then drop EN on ref_rise.
        for (int i = 1; i <= 4; i++) ref_period(10);
        check("pre_dis_trim", 32'(trim), 32'd12);
        check("pre_dis_fault", 32'(fault), 32'd1);
        ref_clk = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_rise_trim", 32'(trim), 32'd8);
        check("en_rise_fault", 32'(fault), 32'd0);
        check("en_rise_lock", 32'(lock), 32'd0);
        ref_clk = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-measurement.
        en = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 3; i++) ref_period(6);
        check("mid_trim", 32'(trim), 32'd10);
        check("mid_count", 32'(count), 32'd6);
        ref_clk = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_trim", 32'(trim), 32'd8);
        check("arst_count", 32'(count), 32'd0);
        check("arst_lock", 32'(lock), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        ref_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("post_trim", 32'(trim), 32'd8);
        check("post_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
